// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, memory arbiter state encoding and requester ids.
package cpu_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_DM = 1'b1;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch and data access,
// data-first with a starvation bound that guarantees fetch progress.
module mem_port_arbiter #(
    parameter int ADDR_W     = cpu_pkg::ADDR_W,
    parameter int DATA_W     = cpu_pkg::DATA_W,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              grant_id
);
    import cpu_pkg::*;
    localparam int LAT_W = $clog2(MEM_LAT + 1);
    localparam int STV_W = $clog2(STARVE_MAX + 1);
    arb_state_t state, state_nxt;
    logic [LAT_W-1:0] lat_cnt;
    logic [STV_W-1:0] starve_cnt;
    logic owner;
    logic any_req;
    logic dm_wins;
    assign any_req  = if_req | dm_req;
    assign dm_wins  = dm_req & (~if_req | (starve_cnt != STV_W'(STARVE_MAX)));
    assign busy     = state != IDLE;
    assign grant_id = busy & owner;
    assign mem_en   = state == ISSUE;
    assign if_ack   = (state == RESP) & (owner == REQ_IF);
    assign dm_ack   = (state == RESP) & (owner == REQ_DM);
    // Stalls are forced low during reset so the whole port reads as quiet.
    assign if_stall = if_req & ~if_ack & ~rst;
    assign dm_stall = dm_req & ~dm_ack & ~rst;
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = any_req ? ISSUE : IDLE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    state_nxt = (lat_cnt == '0) ? RESP : WAIT;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            owner      <= REQ_IF;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: if (any_req) begin
                    owner     <= dm_wins;
                    mem_we    <= dm_wins & dm_we;
                    mem_addr  <= dm_wins ? dm_addr : if_addr;
                    mem_wdata <= dm_wins ? dm_wdata : '0;
                    // DM can only beat a waiting IF below STARVE_MAX, so this saturates.
                    starve_cnt <= dm_wins ? starve_cnt + STV_W'(if_req) : '0;
                end
                ISSUE: lat_cnt <= LAT_W'(MEM_LAT - 1);
                WAIT: if (lat_cnt == '0) begin
                    if (owner == REQ_DM) dm_rdata <= mem_we ? '0 : mem_rdata;
                    else if_rdata <= mem_rdata;
                end else begin
                    lat_cnt <= lat_cnt - LAT_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for two arbiters (MEM_LAT 1 and 3) with a memory model
// that drives garbage outside the single valid read-data cycle.
module tb_mem_port_arbiter;
    typedef struct { int cyc; logic [15:0] data; } ack_t;
    typedef struct { int cyc; logic we; logic [15:0] addr; logic [15:0] wdata; } mem_t;

    logic clk = 1'b0;
    logic rst [2];
    logic if_req [2], if_ack [2], if_stall [2];
    logic dm_req [2], dm_we [2], dm_ack [2], dm_stall [2];
    logic mem_en [2], mem_we [2], busy [2], grant_id [2];
    logic [15:0] if_addr [2], if_rdata [2], dm_addr [2], dm_wdata [2], dm_rdata [2];
    logic [15:0] mem_addr [2], mem_wdata [2];
    logic [15:0] mem [2][0:1023];
    int rd_cyc [2];
    logic [15:0] rd_val [2];
    ack_t if_q [2][$];
    ack_t dm_q [2][$];
    mem_t mq [2][$];
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: event with no expectation (cycle %0d)", name, cyc);
    endtask

    function automatic int lat(input int g);
        return g ? 3 : 1;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : u
        logic [15:0] mrd;
        mem_t me;
        ack_t ae;
        assign mrd = (cyc == rd_cyc[g]) ? rd_val[g] : (16'hBAD0 ^ 16'(cyc));
        mem_port_arbiter #(.MEM_LAT(g ? 3 : 1), .STARVE_MAX(3)) dut (
            .clk(clk), .rst(rst[g]),
            .if_req(if_req[g]), .if_addr(if_addr[g]), .if_ack(if_ack[g]),
            .if_rdata(if_rdata[g]), .if_stall(if_stall[g]),
            .dm_req(dm_req[g]), .dm_we(dm_we[g]), .dm_addr(dm_addr[g]), .dm_wdata(dm_wdata[g]),
            .dm_ack(dm_ack[g]), .dm_rdata(dm_rdata[g]), .dm_stall(dm_stall[g]),
            .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(mrd),
            .busy(busy[g]), .grant_id(grant_id[g])
        );
        always @(negedge clk) begin
            if (mem_en[g]) begin
                if (mq[g].size() == 0) unexpected("mem_en");
                else begin
                    me = mq[g].pop_front();
                    if (me.cyc >= 0) chk("mem_en_cycle", cyc, me.cyc);
                    chk("mem_we", mem_we[g], me.we);
                    chk("mem_addr", mem_addr[g], me.addr);
                    if (me.we) chk("mem_wdata", mem_wdata[g], me.wdata);
                end
                if (mem_we[g]) mem[g][mem_addr[g][9:0]] = mem_wdata[g];
                else begin
                    rd_cyc[g] = cyc + lat(g);
                    rd_val[g] = mem[g][mem_addr[g][9:0]];
                end
            end
            if (if_ack[g]) begin
                if (if_q[g].size() == 0) unexpected("if_ack");
                else begin
                    ae = if_q[g].pop_front();
                    chk("if_ack_cycle", cyc, ae.cyc);
                    chk("if_rdata", if_rdata[g], ae.data);
                end
            end
            if (dm_ack[g]) begin
                if (dm_q[g].size() == 0) unexpected("dm_ack");
                else begin
                    ae = dm_q[g].pop_front();
                    chk("dm_ack_cycle", cyc, ae.cyc);
                    chk("dm_rdata", dm_rdata[g], ae.data);
                end
            end
        end
    end

    task automatic wait_ack(input int g, input logic dm);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (dm ? dm_ack[g] : if_ack[g]) return;
        end
        unexpected(dm ? "dm_ack_timeout" : "if_ack_timeout");
    endtask

    task automatic run_if(input int g, input logic [15:0] addr, input logic [15:0] data);
        int c0;
        @(posedge clk); #1;
        c0 = cyc;
        if_addr[g] = addr;
        if_req[g] = 1'b1;
        mq[g].push_back('{c0 + 1, 1'b0, addr, 16'h0});
        if_q[g].push_back('{c0 + 2 + lat(g), data});
        wait_ack(g, 1'b0);
        @(posedge clk); #1;
        if_req[g] = 1'b0;
    endtask

    task automatic run_dm(input int g, input logic we, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [15:0] data);
        int c0;
        @(posedge clk); #1;
        c0 = cyc;
        dm_we[g] = we;
        dm_addr[g] = addr;
        dm_wdata[g] = wdata;
        dm_req[g] = 1'b1;
        mq[g].push_back('{c0 + 1, we, addr, wdata});
        dm_q[g].push_back('{c0 + 2 + lat(g), data});
        wait_ack(g, 1'b1);
        @(posedge clk); #1;
        dm_req[g] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, r;
        rd_cyc = '{-1, -1};
        for (int g = 0; g < 2; g++) begin
            rst[g] = 1'b1;
            if_req[g] = 1'b0; dm_req[g] = 1'b0; dm_we[g] = 1'b0;
            if_addr[g] = '0; dm_addr[g] = '0; dm_wdata[g] = '0;
            for (int a = 0; a < 1024; a++) mem[g][a] = 16'(a) ^ 16'h6000;
        end
        mem[0][10'h010] = 16'hA5A5; mem[0][10'h020] = 16'h1111;
        mem[0][10'h200] = 16'h5A5A; mem[0][10'h040] = 16'h4444;
        mem[1][10'h200] = 16'h7E57; mem[1][10'h010] = 16'h3C3C;
        #1;
        for (int g = 0; g < 2; g++) begin
            chk("reset_busy", busy[g], 1'b0);
            chk("reset_mem_en", mem_en[g], 1'b0);
            chk("reset_rdata", {if_rdata[g], dm_rdata[g]}, 32'h0);
        end
        repeat (2) @(posedge clk);
        #1 rst = '{1'b0, 1'b0};

        // Lone fetch, latency 1: mem_en in cycle 1, ack in cycle 3, stall cycles 0-2.
        @(posedge clk); #1;
        c0 = cyc;
        if_addr[0] = 16'h0010;
        if_req[0] = 1'b1;
        mq[0].push_back('{c0 + 1, 1'b0, 16'h0010, 16'h0});
        if_q[0].push_back('{c0 + 3, 16'hA5A5});
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t2_if_stall", if_stall[0], k < 3);
            if (k == 1) chk("t2_grant_busy", {grant_id[0], busy[0]}, 2'b01);
        end
        @(posedge clk); #1;
        if_req[0] = 1'b0;
        #1 chk("t2_stall_idle", if_stall[0], 1'b0);

        // Simultaneous requests: DM load first, then IF, with IF stalled throughout.
        @(posedge clk); #1;
        c0 = cyc;
        if_addr[0] = 16'h0020; if_req[0] = 1'b1;
        dm_we[0] = 1'b0; dm_addr[0] = 16'h0200; dm_req[0] = 1'b1;
        mq[0].push_back('{c0 + 1, 1'b0, 16'h0200, 16'h0});
        dm_q[0].push_back('{c0 + 3, 16'h5A5A});
        mq[0].push_back('{c0 + 5, 1'b0, 16'h0020, 16'h0});
        if_q[0].push_back('{c0 + 7, 16'h1111});
        for (int k = 0; k < 8; k++) begin
            if (k == 4) begin
                @(posedge clk); #1;
                dm_req[0] = 1'b0;
            end
            @(negedge clk);
            chk("t3_if_stall", if_stall[0], k < 7);
            if (k == 1) chk("t3_grant_dm", {grant_id[0], mem_we[0]}, 2'b10);
        end
        @(posedge clk); #1;
        if_req[0] = 1'b0;

        // Store then read back; store ack returns zero data.
        run_dm(0, 1'b1, 16'h0300, 16'h1234, 16'h0000);
        run_dm(0, 1'b0, 16'h0300, 16'h0000, 16'h1234);

        // Starvation: both held, DM stores back to back; IF wins every 4th arbitration.
        @(posedge clk); #1;
        c0 = cyc;
        if_addr[0] = 16'h0040; if_req[0] = 1'b1;
        dm_we[0] = 1'b1; dm_addr[0] = 16'h0080; dm_req[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k % 4 == 3) begin
                mq[0].push_back('{c0 + 4 * k + 1, 1'b0, 16'h0040, 16'h0});
                if_q[0].push_back('{c0 + 4 * k + 3, 16'h4444});
            end else begin
                mq[0].push_back('{c0 + 4 * k + 1, 1'b1, 16'h0080, 16'hC000 + 16'(k)});
                dm_q[0].push_back('{c0 + 4 * k + 3, 16'h0000});
            end
        end
        for (int k = 0; k < 8; k++) begin
            dm_wdata[0] = 16'hC000 + 16'(k);
            repeat (4) begin @(posedge clk); #1; end
        end
        if_req[0] = 1'b0; dm_req[0] = 1'b0;

        // Reset mid-WAIT aborts the load; the held request is re-run after release.
        @(posedge clk); #1;
        c0 = cyc;
        dm_we[0] = 1'b0; dm_addr[0] = 16'h0200; dm_req[0] = 1'b1;
        mq[0].push_back('{c0 + 1, 1'b0, 16'h0200, 16'h0});
        repeat (2) begin @(posedge clk); #1; end
        rst[0] = 1'b1;
        #1;
        chk("rst_acks", {if_ack[0], dm_ack[0]}, 2'b00);
        chk("rst_stalls", {if_stall[0], dm_stall[0]}, 2'b00);
        chk("rst_mem_ctl", {mem_en[0], mem_we[0]}, 2'b00);
        chk("rst_mem_bus", {mem_addr[0], mem_wdata[0]}, 32'h0);
        chk("rst_busy_grant", {busy[0], grant_id[0]}, 2'b00);
        chk("rst_rdata", {if_rdata[0], dm_rdata[0]}, 32'h0);
        @(posedge clk); #1;
        rst[0] = 1'b0;
        r = cyc;
        mq[0].push_back('{r + 1, 1'b0, 16'h0200, 16'h0});
        dm_q[0].push_back('{r + 3, 16'h5A5A});
        wait_ack(0, 1'b1);
        @(posedge clk); #1;
        dm_req[0] = 1'b0;

        // Latency 3: ack five cycles after the request cycle, garbage never captured.
        run_dm(1, 1'b0, 16'h0200, 16'h0000, 16'h7E57);
        run_if(1, 16'h0010, 16'h3C3C);
        run_dm(1, 1'b1, 16'h0100, 16'hBEEF, 16'h0000);
        run_dm(1, 1'b0, 16'h0100, 16'h0000, 16'hBEEF);

        repeat (6) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            chk("if_q_left", if_q[g].size(), 0);
            chk("dm_q_left", dm_q[g].size(), 0);
            chk("mem_q_left", mq[g].size(), 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
